dmem_responder: RTL
===================

# dmem_responder

Synchronous data-memory responder for the rv64 pipeline CPU. It services the load/store requests that the memory stage issues. The block accepts one request at a time over a valid/ready channel and performs the byte-lane-masked read or write on an internal word-organised RAM. It returns a response carrying load data right-aligned and zero-extended to the access size. Sign extension stays in the CPU's memory stage.

## Interface
Parameters:
- WIDTH, 64, data and address width in bits
- DEPTH, 4096, number of 64-bit RAM words (power of two)
- BASE, 64'h8000_0000, byte address of word 0
- WAIT_CYCLES, 3, extra access stall cycles (used only with DMEM_WAIT_STATE_EN)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 double
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  CPU accepts response
- rsp_rdata  out  WIDTH  load data, zero-extended; 0 for stores and errors
- rsp_err  out  1  misaligned or out-of-range access

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE: req_ready=1. Handshake (req_valid & req_ready) latches we/size/addr/wdata and moves to ACCESS.
- ACCESS: req_ready=0. Error check and RAM access happen in this state; then move to RESP.
- RESP: rsp_valid=1, and outputs are held stable. On rsp_ready=1, move to IDLE.
- Error conditions:
  - Misaligned: addr[2:0] not a multiple of 2^size.
  - Out of range: addr < BASE or addr >= BASE + DEPTH*8.
  - On error: rsp_err=1, rsp_rdata=0, RAM is not written.
- Indexing: word index = (addr-BASE)[3+log2(DEPTH)-1:3]; byte offset = addr[2:0].
- Store: byte strobe of 2^size ones, shifted left by the offset. wdata is shifted left by offset*8. Only strobed bytes are written, little-endian.
- Load: word >> (offset*8), masked to 8/16/32/64 bits.
- RAM contents are not reset.
- rsp_valid and rsp_ready may be asserted on the same cycle that a new req_valid arrives. req_ready only rises in the cycle after RESP completes, so there are no overlapping requests.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE.
- Latency without the macro:
  - Handshake at cycle N, ACCESS at N+1, rsp_valid=1 at N+2.
  - Minimum spacing between request handshakes is 3 cycles.
- Store commit: RAM write takes effect at the posedge ending ACCESS. A load accepted afterwards observes it.
- Backpressure: RESP persists while rsp_ready=0, with rsp_rdata and rsp_err unchanged.
- Reset mid-operation:
  - rst has priority in every state and forces IDLE.
  - A store whose ACCESS cycle coincides with rst is not committed.
  - A pending response is dropped.
- Requests presented while req_ready=0 are ignored. The requester must hold them.

## Configuration
- DMEM_WAIT_STATE_EN defined:
  - ACCESS lasts 1+WAIT_CYCLES cycles, counted by a down-counter loaded on handshake.
  - The RAM write/read occurs on the final ACCESS cycle.
  - Handshake to rsp_valid is 2+WAIT_CYCLES cycles (5 with the default).
- Not defined: WAIT_CYCLES is ignored, there is no counter, and ACCESS is a single cycle.

## Test plan
- Store/load round trip:
  - Stimulus: sd addr 0x8000_0000 data 0x1122334455667788, then lb addr 0x8000_0003.
  - Required response: rsp_rdata=0x55, rsp_err=0, rsp_valid exactly 2 cycles after each handshake.
- Partial store:
  - Stimulus: after the round trip above, sh addr 0x8000_0002 data 0xBEEF, then ld 0x8000_0000.
  - Required response: rsp_rdata=0x11223344BEEF7788.
- Misaligned:
  - Stimulus: sw addr 0x8000_0002 data 0xFFFF_FFFF.
  - Required response: rsp_err=1, rsp_rdata=0. A following ld 0x8000_0000 still returns 0x11223344BEEF7788.
- Out of range:
  - Stimulus: ld addr 0x7FFF_FFF8, then ld addr 0x8000_8000 (DEPTH=4096).
  - Required response: both give rsp_err=1, rsp_rdata=0.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles during RESP of lwu 0x8000_0004 (data above).
  - Required response: rsp_valid held high, rsp_rdata=0x11223344 stable, req_ready=0 throughout, IDLE one cycle after rsp_ready rises.
- Reset during ACCESS:
  - Stimulus: sd 0x8000_0008 data 0xDEAD, with rst asserted on its ACCESS cycle.
  - Required response: next cycle req_ready=1 and rsp_valid=0. A subsequent ld 0x8000_0008 returns the prior contents, not 0xDEAD.
  - With DMEM_WAIT_STATE_EN, repeat with rst on the last wait cycle, with the same result.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the rv64 core.
// Accepts one load/store over a valid/ready channel, performs a byte-masked
// access on an internal word RAM and returns a zero-extended response.
// Optional build macro DMEM_WAIT_STATE_EN stretches the access phase by
// WAIT_CYCLES extra cycles using a down-counter loaded on handshake.
module dmem_responder #(
  parameter int               WIDTH       = 64,
  parameter int               DEPTH       = 4096,
  parameter logic [WIDTH-1:0] BASE        = WIDTH'(64'h8000_0000),
  parameter int               WAIT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int NB = WIDTH / 8;          // bytes per RAM word
  localparam int OW = $clog2(NB);         // byte-offset bits
  localparam int AW = $clog2(DEPTH);      // word-index bits
  localparam logic [WIDTH-1:0] SPAN = WIDTH'(DEPTH) << OW;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic             we_q,    we_d;
  logic [1:0]       size_q,  size_d;
  logic [WIDTH-1:0] addr_q,  addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

  // Response registers
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q,   rsp_err_d;

  // Word-organised storage, never reset
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Address decode / access datapath
  logic [WIDTH-1:0] off;
  logic [AW-1:0]    idx;
  logic [OW-1:0]    boff;
  logic [OW:0]      nbytes;
  logic             misalign;
  logic             oor;
  logic             acc_err;
  logic [NB-1:0]    strb;
  logic [WIDTH-1:0] wdata_sh;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_mask;
  logic [WIDTH-1:0] rd_val;
  logic             access_last;
  logic             mem_we;
  logic             unused_bits;

  assign off    = addr_q - BASE;
  assign idx    = off[AW+OW-1:OW];
  assign boff   = addr_q[OW-1:0];
  assign nbytes = (OW+1)'(1) << size_q;

  // Alignment: low offset bits under the access size must be zero.
  // For a full-word access nbytes[OW-1:0] wraps to 0, giving an all-ones mask.
  assign misalign = (boff & (nbytes[OW-1:0] - OW'(1))) != '0;
  // Compare the offset rather than BASE+SPAN so the bound never overflows.
  assign oor      = (addr_q < BASE) || (off >= SPAN);
  assign acc_err  = misalign | oor;

  // Strobe of nbytes ones moved to the byte offset; data moved to match.
  assign strb     = (~({NB{1'b1}} << nbytes)) << boff;
  assign wdata_sh = wdata_q << {boff, 3'b000};

  // Load: shift the addressed bytes down, keep only the access size.
  // A full-width shift yields zero, so the mask becomes all ones for doubles.
  assign rd_word = mem_q[idx];
  assign rd_mask = ~({WIDTH{1'b1}} << {nbytes, 3'b000});
  assign rd_val  = (rd_word >> {boff, 3'b000}) & rd_mask;

  assign mem_we  = (state_q == S_ACCESS) && access_last && we_q && !acc_err && !rst;

  // Upper offset bits only matter through the range check above.
  assign unused_bits = ^{off[WIDTH-1:AW+OW], WAIT_CYCLES[0]};

`ifdef DMEM_WAIT_STATE_EN
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  assign access_last = (cnt_q == '0);

  // Wait-state counter: loaded on handshake, counts down through ACCESS
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && req_valid) begin
      cnt_d = CW'(WAIT_CYCLES);
    end else if (state_q == S_ACCESS && !access_last) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Wait-state counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign access_last = 1'b1;
`endif

  // FSM state register; reset wins in every state
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_valid)   state_d = S_ACCESS;
      S_ACCESS: if (access_last) state_d = S_RESP;
      S_RESP:   if (rsp_ready)   state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ready only when idle, valid only in the response state
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
  end

  // Request capture on handshake and response formation at end of ACCESS
  always_comb begin
    we_d        = we_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (state_q == S_IDLE && req_valid) begin
      we_d    = req_we;
      size_d  = req_size;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end
    if (state_q == S_ACCESS && access_last) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err || we_q) ? '0 : rd_val;
    end
  end

  // Request and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      we_q        <= we_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // RAM byte-lane write on the final ACCESS cycle
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (strb[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule
